// File: rtl/dds_pkg.sv
// Shared constants for the DDS sweep controller: DDS register map, AXI codes, FSM states.
package dds_pkg;
  localparam logic [3:0] REG_WAVE_SEL = 4'h0;
  localparam logic [3:0] REG_FREQ0    = 4'h1;
  localparam logic [3:0] REG_PHASE0   = 4'h5;
  localparam logic [3:0] REG_WR_EN    = 4'h9;
  localparam logic [3:0] REG_DATA     = 4'hA;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW_F, ST_W_F, ST_B_F, ST_AW_S, ST_W_S, ST_B_S, ST_DWELL
  } sweep_state_t;

  // Register address of channel ch: base + {ch, offset}
  function automatic logic [31:0] dds_reg_addr(input logic [31:0] base,
                                               input logic [3:0] ch,
                                               input logic [3:0] offs);
    return base + {24'h0, ch, offs};
  endfunction
endpackage

// File: rtl/axi_single_wr.sv
// One-beat AXI write engine: a req pulse captures addr/data, then AW, W and B run in order.
module axi_single_wr (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_aw_hs,
  output logic        o_w_hs,
  output logic        o_ack,
  output logic [1:0]  o_resp,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_awaddr,
  output logic        o_wvalid,
  input  logic        i_wready,
  output logic [31:0] o_wdata,
  output logic        o_bready,
  input  logic        i_bvalid,
  input  logic [1:0]  i_bresp
);
  logic        r_awvalid, r_wvalid, r_bready;
  logic [31:0] r_addr, r_data;

  assign o_aw_hs   = r_awvalid & i_awready;
  assign o_w_hs    = r_wvalid & i_wready;
  assign o_ack     = r_bready & i_bvalid;
  assign o_resp    = i_bresp;
  assign o_awvalid = r_awvalid;
  assign o_awaddr  = r_addr;
  assign o_wvalid  = r_wvalid;
  assign o_wdata   = r_data;
  assign o_bready  = r_bready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      if (o_aw_hs) begin
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b1;
      end
      if (o_w_hs) begin
        r_wvalid <= 1'b0;
        r_bready <= 1'b1;
      end
      if (o_ack) r_bready <= 1'b0;
      // A new request may land on the same edge as the previous B handshake
      if (i_req) begin
        r_awvalid <= 1'b1;
        r_addr    <= i_addr;
        r_data    <= i_data;
      end
    end
  end
endmodule

// File: rtl/dds_sweep_ctrl.sv
// AXI write master sweeping one DDS channel via freq-store/wave_sel page flips.
// Optional DDS_SWEEP_LOOP_EN adds i_sweep_loop for continuous re-sweeping.
module dds_sweep_ctrl import dds_pkg::*; #(
  parameter logic [31:0] DDS_BASE_ADDR = 32'h4000_0000,
  parameter int unsigned CHANNEL_NUM   = 2,
  parameter logic [3:0]  AXI_ID        = 4'h0,
  parameter int          STEP_W        = 16,
  parameter int          DWELL_W       = 24
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sweep_start,
  input  logic               i_sweep_stop,
`ifdef DDS_SWEEP_LOOP_EN
  input  logic               i_sweep_loop,
`endif
  input  logic [3:0]         i_sweep_ch,
  input  logic [31:0]        i_f_start,
  input  logic [31:0]        i_f_step,
  input  logic [STEP_W-1:0]  i_n_points,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic               o_busy,
  output logic               o_done_pulse,
  output logic               o_err,
  output logic [STEP_W-1:0]  o_cur_point,
  output logic               o_m_clk,
  output logic               o_wr_addr_valid,
  input  logic               i_wr_addr_ready,
  output logic [31:0]        o_wr_addr,
  output logic [3:0]         o_wr_addr_id,
  output logic [7:0]         o_wr_addr_len,
  output logic [1:0]         o_wr_addr_burst,
  output logic               o_wr_data_valid,
  input  logic               i_wr_data_ready,
  output logic [31:0]        o_wr_data,
  output logic [3:0]         o_wr_data_strb,
  output logic               o_wr_data_last,
  input  logic               i_wr_back_valid,
  output logic               o_wr_back_ready,
  input  logic [1:0]         i_wr_back_resp,
  output logic               o_rd_addr_valid,
  output logic               o_rd_data_ready
);
  sweep_state_t       r_state;
  logic [3:0]         r_ch;
  logic [31:0]        r_f_start, r_f_step, r_acc;
  logic [STEP_W-1:0]  r_n, r_pt, r_cur_point;
  logic [DWELL_W-1:0] r_dwell, r_cnt;
  logic               r_stop_pend, r_err, r_done;

  logic        w_aw_hs, w_w_hs, w_ack, w_req, w_loop;
  logic [1:0]  w_resp;
  logic [31:0] w_addr, w_data;
  logic [DWELL_W:0] w_cnt_nx;

`ifdef DDS_SWEEP_LOOP_EN
  logic r_loop;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_loop <= 1'b0;
    else if (r_state == ST_IDLE && i_sweep_start && !i_sweep_stop) r_loop <= i_sweep_loop;
  end
  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  wire w_ch_ok      = ({28'h0, i_sweep_ch} < CHANNEL_NUM);
  wire w_stop       = r_stop_pend | i_sweep_stop;
  wire w_resp_ok    = (w_resp == RESP_OKAY);
  assign w_cnt_nx   = {1'b0, r_cnt} + {{DWELL_W{1'b0}}, 1'b1};
  wire w_dwell_done = (w_cnt_nx >= {1'b0, r_dwell});
  wire w_last       = (r_pt == r_n);
  wire w_start_go   = (r_state == ST_IDLE) & i_sweep_start & !i_sweep_stop & w_ch_ok
                      & (i_n_points != '0);
  wire w_bf_go      = (r_state == ST_B_F) & w_ack & w_resp_ok & !w_stop;
  wire w_dw_go      = (r_state == ST_DWELL) & !i_sweep_stop & w_dwell_done & (!w_last | w_loop);

  // Next write is chosen on the same edge the FSM enters the AW state it belongs to
  always_comb begin
    w_req  = w_start_go | w_bf_go | w_dw_go;
    w_addr = dds_reg_addr(DDS_BASE_ADDR, r_ch, REG_FREQ0 + {3'b0, r_pt[0]});
    w_data = r_acc;
    if (w_start_go) begin
      w_addr = dds_reg_addr(DDS_BASE_ADDR, i_sweep_ch, REG_FREQ0);
      w_data = i_f_start;
    end else if (w_bf_go) begin
      w_addr = dds_reg_addr(DDS_BASE_ADDR, r_ch, REG_WAVE_SEL);
      w_data = {31'h0, r_pt[0]};
    end else if (w_last) begin
      w_addr = dds_reg_addr(DDS_BASE_ADDR, r_ch, REG_FREQ0);
      w_data = r_f_start;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ch        <= '0;
      r_f_start   <= '0;
      r_f_step    <= '0;
      r_acc       <= '0;
      r_n         <= '0;
      r_pt        <= '0;
      r_cur_point <= '0;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_sweep_stop && r_state != ST_IDLE && r_state != ST_DWELL) r_stop_pend <= 1'b1;
      case (r_state)
        ST_IDLE: if (i_sweep_start && !i_sweep_stop) begin
          r_ch        <= i_sweep_ch;
          r_f_start   <= i_f_start;
          r_f_step    <= i_f_step;
          r_n         <= i_n_points;
          r_dwell     <= i_dwell;
          r_acc       <= i_f_start;
          r_pt        <= '0;
          r_stop_pend <= 1'b0;
          r_err       <= !w_ch_ok;
          if (w_start_go) r_state <= ST_AW_F;
          else if (w_ch_ok) r_done <= 1'b1;
        end
        ST_AW_F: if (w_aw_hs) r_state <= ST_W_F;
        ST_W_F:  if (w_w_hs)  r_state <= ST_B_F;
        ST_B_F: if (w_ack) begin
          if (!w_resp_ok) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else r_state <= w_stop ? ST_IDLE : ST_AW_S;
        end
        ST_AW_S: if (w_aw_hs) r_state <= ST_W_S;
        ST_W_S:  if (w_w_hs)  r_state <= ST_B_S;
        ST_B_S: if (w_ack) begin
          if (!w_resp_ok) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cur_point <= r_pt;
            r_acc       <= r_acc + r_f_step;
            r_pt        <= r_pt + STEP_W'(1);
            r_cnt       <= '0;
            r_state     <= w_stop ? ST_IDLE : ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (i_sweep_stop) r_state <= ST_IDLE;
          else if (w_dwell_done) begin
            if (!w_last) r_state <= ST_AW_F;
            else if (w_loop) begin
              r_acc   <= r_f_start;
              r_pt    <= '0;
              r_state <= ST_AW_F;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else r_cnt <= r_cnt + DWELL_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  axi_single_wr u_wr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (w_req),
    .i_addr   (w_addr),
    .i_data   (w_data),
    .o_aw_hs  (w_aw_hs),
    .o_w_hs   (w_w_hs),
    .o_ack    (w_ack),
    .o_resp   (w_resp),
    .o_awvalid(o_wr_addr_valid),
    .i_awready(i_wr_addr_ready),
    .o_awaddr (o_wr_addr),
    .o_wvalid (o_wr_data_valid),
    .i_wready (i_wr_data_ready),
    .o_wdata  (o_wr_data),
    .o_bready (o_wr_back_ready),
    .i_bvalid (i_wr_back_valid),
    .i_bresp  (i_wr_back_resp)
  );

  assign o_busy          = (r_state != ST_IDLE);
  assign o_done_pulse    = r_done;
  assign o_err           = r_err;
  assign o_cur_point     = r_cur_point;
  assign o_m_clk         = i_clk;
  assign o_wr_addr_id    = AXI_ID;
  assign o_wr_addr_len   = 8'h00;
  assign o_wr_addr_burst = BURST_INCR;
  assign o_wr_data_strb  = 4'hF;
  assign o_wr_data_last  = 1'b1;
  assign o_rd_addr_valid = 1'b0;
  assign o_rd_data_ready = 1'b1;
endmodule
